// File: rtl/wash_seq_ctrl_if.sv
// Signal bundle between the key scanner / level sensors and the wash sequencer.
// The sequencer uses the slave view; the stimulus side uses the master view.
interface wash_seq_ctrl_if;
  logic [2:0] key_value;
  logic       water_full;
  logic       water_empty;
  logic       valve_in;
  logic       valve_out;
  logic       motor_fwd;
  logic       motor_rev;
  logic       buzzer;
  logic [2:0] state;
  logic [7:0] remain_sec;

  modport master (
    output key_value, water_full, water_empty,
    input  valve_in, valve_out, motor_fwd, motor_rev, buzzer, state, remain_sec
  );

  modport slave (
    input  key_value, water_full, water_empty,
    output valve_in, valve_out, motor_fwd, motor_rev, buzzer, state, remain_sec
  );
endinterface

// File: rtl/wash_seq_ctrl.sv
// Washing-machine cycle sequencer: key-code decode, per-phase second timers
// from a prescaled clock, actuator drive, pause/resume and fault stop.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | waiting for start key
//  FILL   | inlet valve open until drum full / fill-accept, else fault
//  WASH   | motor alternates fwd/rev every REV_SEC s, one-cycle gap
//  DRAIN  | drain valve open until drum empty, else fault
//  SPIN   | drain valve open, motor forward
//  DONE   | buzzer for DONE_SEC s, then back to IDLE
//  PAUSE  | all actuators off, timers frozen, resumes to saved state
//  FAULT  | actuators off, buzzer on, start key returns to IDLE
module wash_seq_ctrl #(
  parameter int unsigned TICK_DIV = 20_000_000,
  parameter int unsigned FILL_TO  = 120,
  parameter int unsigned WASH_SEC = 60,
  parameter int unsigned REV_SEC  = 5,
  parameter int unsigned SPIN_SEC = 30,
  parameter int unsigned DONE_SEC = 3
) (
  input  logic            CLK,
  input  logic            RST_N,
  wash_seq_ctrl_if.slave  bus
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0]    FILL_T    = 8'(FILL_TO);
  localparam logic [7:0]    WASH_T    = 8'(WASH_SEC);
  localparam logic [7:0]    SPIN_T    = 8'(SPIN_SEC);
  localparam logic [7:0]    DONE_T    = 8'(DONE_SEC);
  localparam logic [7:0]    REV_LAST  = 8'(REV_SEC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_DRAIN = 3'd3,
    S_SPIN  = 3'd4,
    S_DONE  = 3'd5,
    S_PAUSE = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  state_t        st;
  state_t        saved_st;
  logic [2:0]    key_prev;
  logic [PW-1:0] presc;
  logic [7:0]    remain;
  logic [7:0]    dir_cnt;
  logic          dir_rev;
  logic          rev_gap;

  logic key_ev;
  logic ev_start;
  logic ev_fill;
  logic ev_pause;
  logic ev_resume;
  logic tick;
  logic last_sec;

  // Key edge decode and one-second tick / final-second detection.
  always_comb begin
    key_ev    = (bus.key_value != key_prev) && (bus.key_value != 3'd0);
    ev_start  = key_ev && (bus.key_value == 3'd1);
    ev_fill   = key_ev && (bus.key_value == 3'd2);
    ev_pause  = key_ev && (bus.key_value == 3'd4);
    ev_resume = key_ev && (bus.key_value == 3'd5);
    tick      = (presc == PRESC_MAX);
    last_sec  = tick && (remain == 8'd1);
  end

  assign bus.state      = st;
  assign bus.remain_sec = remain;

  // Sequencer state, phase timers and registered actuator outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st            <= S_IDLE;
      saved_st      <= S_IDLE;
      key_prev      <= '0;
      presc         <= '0;
      remain        <= '0;
      dir_cnt       <= '0;
      dir_rev       <= 1'b0;
      rev_gap       <= 1'b0;
      bus.valve_in  <= 1'b0;
      bus.valve_out <= 1'b0;
      bus.motor_fwd <= 1'b0;
      bus.motor_rev <= 1'b0;
      bus.buzzer    <= 1'b0;
    end else begin
      key_prev <= bus.key_value;

      // Prescaler and reversal gap are frozen while paused; the cycle that
      // takes the pause still counts, only its tick effect is dropped.
      if (st != S_PAUSE) begin
        presc   <= tick ? '0 : presc + 1'b1;
        rev_gap <= 1'b0;
      end

      case (st)
        S_IDLE: begin
          if (ev_start) begin
            st     <= S_FILL;
            remain <= FILL_T;
            presc  <= '0;
          end
        end
        S_FILL: begin
          if (ev_pause) begin
            saved_st <= st;
            st       <= S_PAUSE;
          end else if (bus.water_full || ev_fill) begin
            st      <= S_WASH;
            remain  <= WASH_T;
            presc   <= '0;
            dir_cnt <= '0;
            dir_rev <= 1'b0;
          end else if (last_sec) begin
            st     <= S_FAULT;
            remain <= '0;
            presc  <= '0;
          end else if (tick) begin
            remain <= remain - 8'd1;
          end
        end
        S_WASH: begin
          if (ev_pause) begin
            saved_st <= st;
            st       <= S_PAUSE;
          end else if (last_sec) begin
            st     <= S_DRAIN;
            remain <= FILL_T;
            presc  <= '0;
          end else if (tick) begin
            remain <= remain - 8'd1;
            if (dir_cnt == REV_LAST) begin
              dir_cnt <= '0;
              dir_rev <= ~dir_rev;
              rev_gap <= 1'b1;
            end else begin
              dir_cnt <= dir_cnt + 8'd1;
            end
          end
        end
        S_DRAIN: begin
          if (ev_pause) begin
            saved_st <= st;
            st       <= S_PAUSE;
          end else if (bus.water_empty) begin
            st     <= S_SPIN;
            remain <= SPIN_T;
            presc  <= '0;
          end else if (last_sec) begin
            st     <= S_FAULT;
            remain <= '0;
            presc  <= '0;
          end else if (tick) begin
            remain <= remain - 8'd1;
          end
        end
        S_SPIN: begin
          if (ev_pause) begin
            saved_st <= st;
            st       <= S_PAUSE;
          end else if (last_sec) begin
            st     <= S_DONE;
            remain <= DONE_T;
            presc  <= '0;
          end else if (tick) begin
            remain <= remain - 8'd1;
          end
        end
        S_DONE: begin
          if (last_sec) begin
            st     <= S_IDLE;
            remain <= '0;
            presc  <= '0;
          end else if (tick) begin
            remain <= remain - 8'd1;
          end
        end
        S_PAUSE: begin
          if (ev_resume) begin
            st <= saved_st;
          end
        end
        S_FAULT: begin
          if (ev_start) begin
            st     <= S_IDLE;
            remain <= '0;
            presc  <= '0;
          end
        end
        default: st <= S_IDLE;
      endcase

      bus.valve_in  <= (st == S_FILL);
      bus.valve_out <= (st == S_DRAIN) || (st == S_SPIN);
      bus.motor_fwd <= (st == S_SPIN) || ((st == S_WASH) && !dir_rev && !rev_gap);
      bus.motor_rev <= (st == S_WASH) && dir_rev && !rev_gap;
      bus.buzzer    <= (st == S_DONE) || (st == S_FAULT);
    end
  end

endmodule
